// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin arbiter sharing one shift-add multiplier between two clients.
// Rev 1.0 - initial release.
`default_nettype none

module mult_share_arb #(
   parameter int WIDTH       = 16,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0,
   input  logic               req1,
   input  logic [WIDTH-1:0]   a0,
   input  logic [WIDTH-1:0]   b0,
   input  logic [WIDTH-1:0]   a1,
   input  logic [WIDTH-1:0]   b1,
   output logic               ack0,
   output logic               ack1,
   output logic [2*WIDTH-1:0] result,
   output logic               err,
   output logic               busy,
   output logic               gnt_id,
   output logic [WIDTH-1:0]   mult_a,
   output logic [WIDTH-1:0]   mult_b,
   output logic               mult_init,
   input  logic               mult_done_n,
   input  logic [2*WIDTH-1:0] mult_pp
);

   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2,
      ACK       = 2'd3
   } state_t;

   state_t           state;
   logic             prio;
   logic [CNT_W-1:0] cnt;
   logic             pick;

   // prio names the client that wins a tie; a lone request always wins.
   assign pick = (req0 && req1) ? prio : req1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         prio      <= 1'b0;
         cnt       <= '0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         result    <= '0;
         err       <= 1'b0;
         busy      <= 1'b0;
         gnt_id    <= 1'b0;
         mult_a    <= '0;
         mult_b    <= '0;
         mult_init <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  gnt_id    <= pick;
                  mult_a    <= pick ? a1 : a0;
                  mult_b    <= pick ? b1 : b0;
                  prio      <= ~pick;
                  cnt       <= '0;
                  mult_init <= 1'b1;
                  busy      <= 1'b1;
                  state     <= LAUNCH;
               end
            end
            LAUNCH: begin
               if (cnt == TO_LAST) begin
                  result    <= '0;
                  err       <= 1'b1;
                  mult_init <= 1'b0;
                  ack0      <= ~gnt_id;
                  ack1      <= gnt_id;
                  state     <= ACK;
               end else begin
                  cnt <= cnt + 1'b1;
                  // Init is held until the multiplier leaves any finished state left over from a prior job.
                  if (mult_done_n) begin
                     mult_init <= 1'b0;
                     state     <= WAIT_DONE;
                  end
               end
            end
            WAIT_DONE: begin
               if (cnt == TO_LAST) begin
                  result <= '0;
                  err    <= 1'b1;
                  ack0   <= ~gnt_id;
                  ack1   <= gnt_id;
                  state  <= ACK;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (!mult_done_n) begin
                     result <= mult_pp;
                     err    <= 1'b0;
                     ack0   <= ~gnt_id;
                     ack1   <= gnt_id;
                     state  <= ACK;
                  end
               end
            end
            ACK: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy      <= 1'b0;
               mult_init <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
